// File: rtl/hint_pkg.sv
// Shared definitions for the streaming ML-DSA hint unpacker.
//
// Contents:
//   N           coefficients per polynomial (fixed at 256)
//   state_t     decoder FSM states
//   idx_width   width of a position index that can reach OMEGA
//   poly_width  width of a polynomial index that can reach K
package hint_pkg;

  localparam int N = 256;

  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    LIMIT = 3'd1,
    POS   = 3'd2,
    ZERO  = 3'd3,
    DONE  = 3'd4
  } state_t;

  // idx counts 0..OMEGA inclusive
  function automatic int idx_width(input int omega);
    return $clog2(omega + 1);
  endfunction

  // i counts 0..K inclusive
  function automatic int poly_width(input int k);
    return $clog2(k + 1);
  endfunction

endpackage

// File: rtl/hint_bit_unpack_stream_pos_buf.sv
// Position buffer for the hint unpacker: OMEGA entries of 8 bits.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   i_we, i_waddr,
//   i_wdata             single write port, used while bytes are loaded
//   i_raddr_a/o_rdata_a combinational read at the current index
//   i_raddr_b/o_rdata_b combinational read at the previous index
// Reads of an address outside 0..OMEGA-1 return 0.
module hint_pos_buf
  import hint_pkg::*;
#(
  parameter int OMEGA = 75,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [7:0]    o_rdata_a,
  input  logic [AW-1:0] i_raddr_b,
  output logic [7:0]    o_rdata_b
);

  logic [7:0] r_mem [OMEGA];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < OMEGA; k++) r_mem[k] <= 8'h00;
    end else if (i_we) begin
      for (int k = 0; k < OMEGA; k++) begin
        if (i_waddr == AW'(k)) r_mem[k] <= i_wdata;
      end
    end
  end

  // Decoded read muxes keep out-of-range addresses (idx-1 at idx=0,
  // idx=OMEGA) harmless without relying on array bounds behaviour.
  always_comb begin
    o_rdata_a = 8'h00;
    o_rdata_b = 8'h00;
    for (int k = 0; k < OMEGA; k++) begin
      if (i_raddr_a == AW'(k)) o_rdata_a = r_mem[k];
      if (i_raddr_b == AW'(k)) o_rdata_b = r_mem[k];
    end
  end

endmodule

// File: rtl/hint_bit_unpack_stream.sv
// Streaming ML-DSA HintBitUnpack.
//
// Accepts the OMEGA+K encoding bytes one per cycle, rebuilds the K x N
// hint vector h and rejects malformed encodings.
//
// Handshake: a byte moves on a clock edge where in_valid and in_ready are
// both high; in_ready is only ever high in LOAD, so in_valid is ignored
// (and the byte kept by the sender) while a frame is being decoded.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   in_valid     in_data carries a byte
//   in_data      encoding byte y[j], j = 0..OMEGA+K-1 in order
//   in_ready     a byte is accepted this cycle
//   h            hint vector, bit i*N+c is h[i][c]
//   valid        h / malformed are final; held until the next frame starts
//   malformed    encoding rejected (h is then all zero)
//   o_dbg_state  current decoder state
//
// Decode timing for a well-formed frame: K LIMIT cycles, limit[K-1] POS
// cycles and OMEGA-limit[K-1] ZERO cycles, i.e. always K+OMEGA cycles,
// followed by one DONE cycle that raises valid.
module hint_bit_unpack_stream
  import hint_pkg::*;
#(
  parameter int K     = 8,
  parameter int OMEGA = 75
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  input  logic [7:0]     in_data,
  output logic           in_ready,
  output logic [K*N-1:0] h,
  output logic           valid,
  output logic           malformed,
  output state_t         o_dbg_state
);

  localparam int IW = idx_width(OMEGA);
  localparam int PW = poly_width(K);
  localparam int JW = $clog2(OMEGA + K + 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [JW-1:0]       r_j;
  logic [PW-1:0]       r_i;
  logic [IW-1:0]       r_idx;
  logic [IW-1:0]       r_start;
  logic [7:0]          r_limit [K];
  logic [K-1:0][N-1:0] r_h;
  logic                r_valid;
  logic                r_malformed;
  logic                r_in_ready;

  logic          w_accept;
  logic          w_last_byte;
  logic          w_buf_we;
  logic [7:0]    w_rd_cur;
  logic [7:0]    w_rd_prev;
  logic [7:0]    w_lim;
  logic [8:0]    w_lim9;
  logic [8:0]    w_idx9;
  logic [IW-1:0] w_idx_nx;
  logic [IW-1:0] w_idx_prev;
  logic          w_last_poly;
  logic          w_idx_at_end;
  logic          w_nx_at_end;

  logic          w_malf;
  logic          w_set_bit;
  logic          w_idx_inc;
  logic          w_poly_inc;
  logic          w_load_start;

  assign in_ready    = r_in_ready;
  assign h           = r_h;
  assign valid       = r_valid;
  assign malformed   = r_malformed;
  assign o_dbg_state = r_state;

  assign w_accept     = in_valid & r_in_ready;
  assign w_last_byte  = (r_j == JW'(OMEGA + K - 1));
  assign w_buf_we     = w_accept && (r_j < JW'(OMEGA));
  assign w_idx_nx     = r_idx + IW'(1);
  assign w_idx_prev   = r_idx - IW'(1);
  assign w_lim9       = {1'b0, w_lim};
  assign w_idx9       = 9'(r_idx);
  assign w_last_poly  = (r_i == PW'(K - 1));
  assign w_idx_at_end = (r_idx == IW'(OMEGA));
  assign w_nx_at_end  = (w_idx_nx == IW'(OMEGA));

  hint_pos_buf #(
    .OMEGA (OMEGA),
    .AW    (IW)
  ) u_pos_buf (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_buf_we),
    .i_waddr   (IW'(r_j)),
    .i_wdata   (in_data),
    .i_raddr_a (r_idx),
    .o_rdata_a (w_rd_cur),
    .i_raddr_b (w_idx_prev),
    .o_rdata_b (w_rd_prev)
  );

  // limit[i] for the polynomial currently being decoded
  always_comb begin
    w_lim = 8'h00;
    for (int kk = 0; kk < K; kk++) begin
      if (r_i == PW'(kk)) w_lim = r_limit[kk];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= LOAD;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_malf       = 1'b0;
    w_set_bit    = 1'b0;
    w_idx_inc    = 1'b0;
    w_poly_inc   = 1'b0;
    w_load_start = 1'b0;
    case (r_state)
      LOAD: begin
        if (w_accept && w_last_byte) w_next_state = LIMIT;
      end
      LIMIT: begin
        w_load_start = 1'b1;
        if ((w_lim9 < w_idx9) || (w_lim9 > 9'(OMEGA))) begin
          w_malf       = 1'b1;
          w_next_state = DONE;
        end else if (w_lim9 == w_idx9) begin
          // Empty polynomial: skip POS entirely.
          w_poly_inc = 1'b1;
          if (!w_last_poly)     w_next_state = LIMIT;
          else if (w_idx_at_end) w_next_state = DONE;
          else                  w_next_state = ZERO;
        end else begin
          w_next_state = POS;
        end
      end
      POS: begin
        // Positions inside one polynomial must be strictly increasing.
        if ((r_idx != r_start) && (w_rd_cur <= w_rd_prev)) begin
          w_malf       = 1'b1;
          w_next_state = DONE;
        end else begin
          w_set_bit = 1'b1;
          w_idx_inc = 1'b1;
          if (9'(w_idx_nx) == w_lim9) begin
            w_poly_inc = 1'b1;
            if (!w_last_poly)     w_next_state = LIMIT;
            else if (w_nx_at_end) w_next_state = DONE;
            else                  w_next_state = ZERO;
          end
        end
      end
      ZERO: begin
        // Unused position slots must be zero padding.
        if (w_rd_cur != 8'h00) begin
          w_malf       = 1'b1;
          w_next_state = DONE;
        end else begin
          w_idx_inc = 1'b1;
          if (w_nx_at_end) w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = LOAD;
      end
      default: begin
        w_next_state = LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_j         <= '0;
      r_i         <= '0;
      r_idx       <= '0;
      r_start     <= '0;
      r_h         <= '0;
      r_valid     <= 1'b0;
      r_malformed <= 1'b0;
      r_in_ready  <= 1'b0;
      for (int kk = 0; kk < K; kk++) r_limit[kk] <= 8'h00;
    end else begin
      r_in_ready <= (w_next_state == LOAD);

      if (w_accept) begin
        // First byte of a new frame retires the previous result.
        if (r_j == '0) begin
          r_valid     <= 1'b0;
          r_malformed <= 1'b0;
          r_h         <= '0;
        end
        for (int kk = 0; kk < K; kk++) begin
          if (r_j == JW'(OMEGA + kk)) r_limit[kk] <= in_data;
        end
        if (w_last_byte) begin
          r_j   <= '0;
          r_i   <= '0;
          r_idx <= '0;
        end else begin
          r_j <= r_j + JW'(1);
        end
      end

      if (w_load_start) r_start <= r_idx;

      if (w_set_bit) begin
        for (int kk = 0; kk < K; kk++) begin
          if (r_i == PW'(kk)) r_h[kk][w_rd_cur] <= 1'b1;
        end
      end

      if (w_idx_inc)  r_idx <= w_idx_nx;
      if (w_poly_inc) r_i   <= r_i + PW'(1);

      if (w_malf) begin
        r_malformed <= 1'b1;
        r_h         <= '0;
      end

      if (r_state == DONE) r_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_hint_bit_unpack_stream.sv
// Bench for hint_bit_unpack_stream: a small instance (K=4, OMEGA=8) and a
// default-size instance (K=8, OMEGA=75) share one clock and reset. Frames
// are pushed with their expected decode into per-instance queues; a monitor
// per instance pops and compares whenever valid rises.
module tb_hint_bit_unpack_stream;
  import hint_pkg::*;

  localparam int KA = 4;
  localparam int OA = 8;
  localparam int KB = 8;
  localparam int OB = 75;

  logic clk;
  logic rst;

  logic             a_in_valid, a_in_ready, a_valid, a_malformed;
  logic [7:0]       a_in_data;
  logic [KA*N-1:0]  a_h;
  state_t           a_state;

  logic             b_in_valid, b_in_ready, b_valid, b_malformed;
  logic [7:0]       b_in_data;
  logic [KB*N-1:0]  b_h;
  state_t           b_state;

  int total = 0;
  int bad   = 0;

  logic [2048:0] exp_a_q[$];
  logic [2048:0] exp_b_q[$];

  hint_bit_unpack_stream #(.K(KA), .OMEGA(OA)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_ready(a_in_ready), .h(a_h), .valid(a_valid), .malformed(a_malformed),
    .o_dbg_state(a_state)
  );

  hint_bit_unpack_stream #(.K(KB), .OMEGA(OB)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_ready(b_in_ready), .h(b_h), .valid(b_valid), .malformed(b_malformed),
    .o_dbg_state(b_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_h(input string nm, input logic [2047:0] act, input logic [2047:0] exp);
    int first;
    total++;
    if (act !== exp) begin
      bad++;
      first = 0;
      for (int b = 2047; b >= 0; b--) if (act[b] !== exp[b]) first = b;
      $display("FAIL %s first differing bit %0d act=%0b exp=%0b ones act=%0d exp=%0d",
               nm, first, act[first], exp[first], $countones(act), $countones(exp));
    end
  endtask

  task automatic report_and_finish();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  // ---------------- reference model ----------------
  // Direct transcription of HintBitUnpack: returns {malformed, h}.
  function automatic logic [2048:0] ref_model(input int k, input int om, input logic [7:0] y[$]);
    logic [2047:0] hv;
    bit            rej;
    int            idx, first, lim;
    hv  = '0;
    rej = 0;
    idx = 0;
    for (int i = 0; i < k && !rej; i++) begin
      lim = int'(y[om + i]);
      if (lim < idx || lim > om) rej = 1;
      else begin
        first = idx;
        while (idx < lim && !rej) begin
          if (idx > first && y[idx - 1] >= y[idx]) rej = 1;
          else hv[i * 256 + int'(y[idx])] = 1'b1;
          idx++;
        end
      end
    end
    if (!rej) for (int t = idx; t < om; t++) if (y[t] != 8'h00) rej = 1;
    if (rej) hv = '0;
    return {rej, hv};
  endfunction

  // Random frame: ascending positions per polynomial (slots of 32 so they
  // are strictly increasing), zero padding, then limits; sometimes a byte
  // is overwritten with noise so the malformed rules get exercised.
  task automatic gen_frame(input int k, input int om, output logic [7:0] yq[$]);
    logic [7:0] lims[$];
    int rem, cnt, hi;
    yq  = {};
    rem = om;
    for (int i = 0; i < k; i++) begin
      hi  = (rem < 8) ? rem : 8;
      cnt = int'($urandom_range(0, hi));
      for (int c = 0; c < cnt; c++) yq.push_back(8'(c * 32 + int'($urandom_range(0, 31))));
      rem -= cnt;
      lims.push_back(8'(om - rem));
    end
    while (yq.size() < om) yq.push_back(8'h00);
    foreach (lims[t]) yq.push_back(lims[t]);
    if ($urandom_range(0, 2) == 0) yq[$urandom_range(0, om + k - 1)] = 8'($urandom_range(0, 255));
  endtask

  // ---------------- driver ----------------
  // Inputs change #1 after posedge; in_ready is sampled at the negedge
  // before the edge that would consume the byte.
  task automatic send(input int sel, input logic [7:0] y[$], input bit push, input int gap_max);
    logic rdy;
    int   t;
    if (push) begin
      if (sel == 0) exp_a_q.push_back(ref_model(KA, OA, y));
      else          exp_b_q.push_back(ref_model(KB, OB, y));
    end
    foreach (y[j]) begin
      if (gap_max > 0 && $urandom_range(0, 3) == 0) begin
        if (sel == 0) a_in_valid = 1'b0; else b_in_valid = 1'b0;
        repeat ($urandom_range(1, gap_max)) begin
          @(posedge clk); #1;
        end
      end
      if (sel == 0) begin a_in_valid = 1'b1; a_in_data = y[j]; end
      else          begin b_in_valid = 1'b1; b_in_data = y[j]; end
      t = 0;
      forever begin
        @(negedge clk);
        rdy = (sel == 0) ? a_in_ready : b_in_ready;
        @(posedge clk); #1;
        if (rdy) break;
        t++;
        if (t > 2000) begin
          total++;
          bad++;
          $display("FAIL in_ready_timeout sel=%0d byte=%0d", sel, j);
          report_and_finish();
        end
      end
    end
    if (sel == 0) a_in_valid = 1'b0; else b_in_valid = 1'b0;
  endtask

  task automatic drain(input int sel);
    int t;
    t = 0;
    while (((sel == 0) ? exp_a_q.size() : exp_b_q.size()) != 0) begin
      @(posedge clk);
      t++;
      if (t > 3000) begin
        total++;
        bad++;
        $display("FAIL drain_timeout sel=%0d pending=%0d", sel,
                 (sel == 0) ? exp_a_q.size() : exp_b_q.size());
        break;
      end
    end
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  // Handshakes are sampled half a cycle before their accepting edge and
  // valid half a cycle after its rising edge, hence the "- 1" in lat.
  task automatic monitor(input int sel);
    int            k, om, nb;
    longint        cyc, hs_cyc, lat;
    logic          vprev, v, m, iv, ir;
    logic [2047:0] act;
    logic [2048:0] e;
    string         p;
    k      = (sel == 0) ? KA : KB;
    om     = (sel == 0) ? OA : OB;
    p      = (sel == 0) ? "a" : "b";
    nb     = 0;
    cyc    = 0;
    hs_cyc = 0;
    vprev  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      v   = (sel == 0) ? a_valid : b_valid;
      m   = (sel == 0) ? a_malformed : b_malformed;
      iv  = (sel == 0) ? a_in_valid : b_in_valid;
      ir  = (sel == 0) ? a_in_ready : b_in_ready;
      act = (sel == 0) ? 2048'(a_h) : 2048'(b_h);
      if (rst) begin
        nb    = 0;
        vprev = 1'b0;
        continue;
      end
      if (iv && ir) begin
        nb++;
        if (nb == om + k) begin
          hs_cyc = cyc;
          nb     = 0;
        end
      end
      if (v && !vprev) begin
        if (((sel == 0) ? exp_a_q.size() : exp_b_q.size()) == 0) begin
          total++;
          bad++;
          $display("FAIL %s.unexpected_valid act=1 exp=0", p);
        end else begin
          e   = (sel == 0) ? exp_a_q.pop_front() : exp_b_q.pop_front();
          lat = cyc - hs_cyc - 1;
          chk({p, ".malformed"}, longint'(m), longint'(e[2048]));
          chk_h({p, ".h"}, act, e[2047:0]);
          if (!e[2048]) chk({p, ".latency"}, lat, longint'(k + om + 1));
          else begin
            total++;
            if (lat < 1 || lat > k + om + 1) begin
              bad++;
              $display("FAIL %s.malformed_latency act=%0d exp<=%0d", p, lat, k + om + 1);
            end
          end
        end
      end
      vprev = v;
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v1[$], v[$], vb[$];

    rst        = 1'b1;
    a_in_valid = 1'b0;
    a_in_data  = 8'h00;
    b_in_valid = 1'b0;
    b_in_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset values, then LOAD with in_ready raised one cycle later
    @(negedge clk);
    chk("rst.a_in_ready", longint'(a_in_ready), 0);
    chk("rst.a_valid", longint'(a_valid), 0);
    chk("rst.a_malformed", longint'(a_malformed), 0);
    chk_h("rst.a_h", 2048'(a_h), '0);
    chk("rst.b_valid", longint'(b_valid), 0);
    chk("rst.a_state", longint'(a_state), longint'(LOAD));
    @(negedge clk);
    chk("rst.a_in_ready_after", longint'(a_in_ready), 1);
    @(posedge clk); #1;

    // small instance: directed frames
    v1 = {8'h01, 8'h0a, 8'h07, 8'h00, 8'hff, 8'h00, 8'h00, 8'h00,
          8'h02, 8'h03, 8'h03, 8'h05};
    send(0, v1, 1, 0);
    v = v1; v[0] = 8'h0a; v[1] = 8'h01;            // non-increasing in poly 0
    send(0, v, 1, 0);
    v = v1; v[8] = 8'h03; v[9] = 8'h02;            // decreasing limit
    send(0, v, 1, 0);
    v = v1; v[11] = 8'h09;                         // limit above OMEGA
    send(0, v, 1, 0);
    v = v1; v[7] = 8'h01;                          // nonzero padding
    send(0, v, 1, 0);
    v = {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
         8'h00, 8'h00, 8'h00, 8'h00};              // no hints at all
    send(0, v, 1, 0);
    v = {8'h00, 8'hff, 8'h10, 8'h20, 8'h30, 8'h31, 8'hfe, 8'hff,
         8'h02, 8'h04, 8'h06, 8'h08};              // every slot used
    send(0, v, 1, 0);
    send(0, v1, 1, 3);                             // same frame with gaps

    // random frames, back to back and with gaps
    for (int n = 0; n < 40; n++) begin
      gen_frame(KA, OA, v);
      send(0, v, 1, (n % 2 == 1) ? 3 : 0);
    end
    drain(0);

    // abort a frame during POS, then a clean frame
    send(0, v1, 0, 0);
    @(posedge clk); #1;
    chk("abort.state_pos", longint'(a_state), longint'(POS));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort.a_valid", longint'(a_valid), 0);
    chk("abort.a_malformed", longint'(a_malformed), 0);
    chk_h("abort.a_h", 2048'(a_h), '0);
    @(posedge clk); #1;
    send(0, v1, 1, 0);
    drain(0);

    // default-size instance: reference vector and its malformed variant
    vb = {8'h05, 8'h02, 8'h02, 8'h02, 8'h02, 8'h00, 8'h01, 8'h07, 8'h08, 8'h09, 8'h0a};
    for (int r = 0; r < 2; r++)
      for (int m = 0; m < 32; m++) vb.push_back(8'(2 + 8 * m));
    vb = {vb, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0b, 8'h2b, 8'h4b};
    send(1, vb, 1, 0);
    v = vb;
    v[OB + 2] = 8'h02; v[OB + 3] = 8'h02; v[OB + 4] = 8'h04;
    send(1, v, 1, 0);
    send(1, vb, 1, 2);
    for (int n = 0; n < 8; n++) begin
      gen_frame(KB, OB, v);
      send(1, v, 1, (n % 2 == 1) ? 2 : 0);
    end
    drain(1);

    repeat (5) @(posedge clk);
    report_and_finish();
  end

endmodule
